lsu_unit: RTL and testbench
===========================

// Module: lsu_unit
// PURPOSE
//  Load/store unit of the RV32 multi-cycle core; consumes the decoded mem_op_t, effective address and
//  store data from the execute stage, and produces the extended load result for writeback (WB_MEM).
//  Drives a word-addressed data-memory port with a req/gnt + rvalid handshake.
//  Checks alignment and the RAM window, and bounds the load wait with a timeout.
// PARAMETERS
//  TIMEOUT_CYCLES  16  max cycles in WAIT for dmem_rvalid_i before a timeout error (>=2)
// PORTS
//  clk_i          in   1   clock; all state updates on rising edge
//  rst_i          in   1   synchronous, active-high reset
//  req_valid_i    in   1   execute stage presents a memory operation
//  req_ready_o    out  1   LSU idle and accepting (high only in IDLE)
//  mem_op_i       in   3   mem_op_t (MEM_LB..MEM_SW)
//  addr_i         in   32  byte effective address
//  wdata_i        in   32  store data (rs2), low bits significant for SB/SH
//  dmem_req_o     out  1   memory request, held until granted
//  dmem_we_o      out  1   1 = store
//  dmem_addr_o    out  30  word address = addr[31:2]
//  dmem_be_o      out  4   byte enables
//  dmem_wdata_o   out  32  lane-replicated store data
//  dmem_gnt_i     in   1   request accepted this cycle
//  dmem_rvalid_i  in   1   load data valid this cycle
//  dmem_rdata_i   in   32  load word
//  rsp_valid_o    out  1   one-cycle completion pulse
//  rsp_rdata_o    out  32  extended load result (0 for stores and errors)
//  rsp_err_o      out  2   lsu_err_t: 00 NONE, 01 MISALIGN, 10 ACCESS, 11 TIMEOUT
// BEHAVIOUR
//  Reset: state IDLE; req_ready_o=1; dmem_req_o, dmem_we_o, rsp_valid_o=0; dmem_addr_o, dmem_be_o,
//    dmem_wdata_o, rsp_rdata_o, rsp_err_o = 0; timeout counter = 0. Reset mid-op aborts with no response.
//  FSM: IDLE -> REQ -> (WAIT) -> RESP -> IDLE.
//  IDLE: if req_valid_i, register op/addr/wdata. Misaligned (LH/LHU/SH addr[0]=1; LW/SW addr[1:0]!=0)
//    -> RESP, MISALIGN. Else addr[31:2] outside [RAM_LOWER, RAM_HIGHER] -> RESP, ACCESS.
//    Else -> REQ. MISALIGN takes priority over ACCESS. No dmem_req_o is issued on an error.
//  REQ: dmem_req_o=1 with stable addr/we/be/wdata until dmem_gnt_i. On gnt, a store -> RESP (NONE);
//    a load -> WAIT with counter cleared. Gnt in the first REQ cycle is legal (same-cycle grant).
//  WAIT: counter increments each cycle. dmem_rvalid_i -> RESP with extracted data. If counter reaches
//    TIMEOUT_CYCLES-1 without rvalid -> RESP, TIMEOUT. rvalid in the same cycle as the limit wins.
//  RESP: rsp_valid_o=1 for exactly one cycle with rdata/err, then IDLE (no back-pressure).
//    rvalid seen outside WAIT is ignored.
//  Min latency, accept to rsp_valid_o: store 2 cycles (gnt in REQ); load 3 cycles (rvalid in first WAIT cycle).
//  Byte enables: SB 4'b0001<<addr[1:0]; SH 4'b0011<<{addr[1],1'b0}; SW 4'b1111.
//  Store data: SB {4{wdata[7:0]}}; SH {2{wdata[15:0]}}; SW wdata.
//  Load extract: byte/half selected by addr[1:0]/addr[1]. LB/LH sign-extend; LBU/LHU zero-extend;
//    LW passes the full word.
// STRUCTURE
//  Package additions: lsu_state_t enum (IDLE, REQ, WAIT, RESP); lsu_err_t enum.
//    Reuse mem_op_t, RAM_LOWER and RAM_HIGHER.
//  Sub-module lsu_align: purely combinational be/wdata generation and load extract/extend,
//    instantiated once. FSM and counter stay in lsu_unit.
// TESTING
//  1. LB at 0x8000_0003, rdata 0x80FF_1234, rvalid 1 cycle after gnt -> rsp_rdata 0xFFFF_FF80, err 00.
//  2. SH 0xABCD_5678 at 0x8000_0102 -> dmem_addr 0x2000_0040, be 4'b1100, wdata 0x5678_5678,
//     one rsp pulse, rdata 0.
//  3. LW at 0x8000_0006 -> rsp in 2nd cycle, err 01, dmem_req_o never asserted.
//     LHU at 0x0000_0010 -> err 10.
//  4. gnt withheld 5 cycles: req/addr/be stable throughout. LW, no rvalid -> err 11 after
//     TIMEOUT_CYCLES WAIT cycles.
//  5. rst_i pulsed in WAIT, then late rvalid -> no rsp_valid_o, back in IDLE, req_ready_o=1.
//  6. Back-to-back LBU/LHU/LW with rvalid on the timeout-limit cycle -> data returned, err 00,
//     zero-extension correct.

Source files
------------

// File: rtl/lsu_unit_pkg.sv
// Shared types for the RV32 load/store unit.
//   mem_op_t    : decoded memory operation from execute
//   lsu_state_t : LSU control FSM states
//   lsu_err_t   : response error code
//   lsu_req_t   : operation latched at accept
// RAM window limits are word addresses (byte address [31:2]).
package lsu_unit_pkg;

    typedef enum logic [2:0] {
        MEM_LB  = 3'd0,
        MEM_LH  = 3'd1,
        MEM_LW  = 3'd2,
        MEM_LBU = 3'd3,
        MEM_LHU = 3'd4,
        MEM_SB  = 3'd5,
        MEM_SH  = 3'd6,
        MEM_SW  = 3'd7
    } mem_op_t;

    // 64 KiB RAM at 0x8000_0000
    localparam logic [29:0] RAM_LOWER  = 30'h2000_0000;
    localparam logic [29:0] RAM_HIGHER = 30'h2000_3FFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } lsu_state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_ACCESS   = 2'b10,
        ERR_TIMEOUT  = 2'b11
    } lsu_err_t;

    typedef struct packed {
        mem_op_t     op;
        logic [31:0] addr;
        logic [31:0] wdata;
    } lsu_req_t;

    function automatic logic is_store(input mem_op_t op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

    function automatic logic is_misaligned(input mem_op_t op, input logic [1:0] lo);
        case (op)
            MEM_LH, MEM_LHU, MEM_SH: return lo[0];
            MEM_LW, MEM_SW:          return lo != 2'b00;
            default:                 return 1'b0;
        endcase
    endfunction

    function automatic logic in_ram(input logic [29:0] waddr);
        return (waddr >= RAM_LOWER) && (waddr <= RAM_HIGHER);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane handling for the LSU.
//   op, addr_lo  : latched operation and byte offset
//   wdata        : store data (rs2)
//   rdata        : raw load word from memory
//   be           : byte enables (stores only, 0 for loads)
//   store_data   : lane-replicated store word (0 for loads)
//   load_data    : extracted and extended load result
module lsu_align
    import lsu_unit_pkg::*;
(
    input  mem_op_t     op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] store_data,
    output logic [31:0] load_data
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    // Memory returns the whole word; byte enables only qualify writes.
    always_comb begin
        be         = 4'b0000;
        store_data = 32'h0;
        case (op)
            MEM_SB: begin
                be         = 4'b0001 << addr_lo;
                store_data = {4{wdata[7:0]}};
            end
            MEM_SH: begin
                be         = 4'b0011 << {addr_lo[1], 1'b0};
                store_data = {2{wdata[15:0]}};
            end
            MEM_SW: begin
                be         = 4'b1111;
                store_data = wdata;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (addr_lo)
            2'd0:    rd_byte = rdata[7:0];
            2'd1:    rd_byte = rdata[15:8];
            2'd2:    rd_byte = rdata[23:16];
            default: rd_byte = rdata[31:24];
        endcase
        rd_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        case (op)
            MEM_LB:  load_data = {{24{rd_byte[7]}}, rd_byte};
            MEM_LBU: load_data = {24'h0, rd_byte};
            MEM_LH:  load_data = {{16{rd_half[15]}}, rd_half};
            MEM_LHU: load_data = {16'h0, rd_half};
            MEM_LW:  load_data = rdata;
            default: load_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/lsu_unit.sv
// Load/store unit: accepts one memory op from execute, checks alignment
// and the RAM window, runs a req/gnt + rvalid transaction on the word-
// addressed data port and returns a one-cycle response to writeback.
//   clk_i, rst_i        : clock, synchronous active-high reset
//   req_valid_i/ready_o : execute handshake (ready only in IDLE)
//   mem_op_i, addr_i, wdata_i : operation, byte address, store data
//   dmem_*              : data-memory port (req held until gnt)
//   rsp_valid_o/rdata_o/err_o : completion pulse, load result, error
module lsu_unit
    import lsu_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [2:0]  mem_op_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [29:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_gnt_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic [1:0]  rsp_err_o
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_t       state;
    lsu_req_t         req_q;
    logic [CNT_W-1:0] wait_cnt;
    lsu_err_t         rsp_err_q;
    logic [31:0]      load_data;
    mem_op_t          op_in;

    assign op_in = mem_op_t'(mem_op_i);

    // Port fields come straight from the latched request, so they are
    // stable for the whole REQ phase without extra holding registers.
    lsu_align u_align (
        .op         (req_q.op),
        .addr_lo    (req_q.addr[1:0]),
        .wdata      (req_q.wdata),
        .rdata      (dmem_rdata_i),
        .be         (dmem_be_o),
        .store_data (dmem_wdata_o),
        .load_data  (load_data)
    );

    assign req_ready_o = (state == IDLE);
    assign dmem_we_o   = is_store(req_q.op);
    assign dmem_addr_o = req_q.addr[31:2];
    assign rsp_err_o   = rsp_err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            req_q       <= '{op: MEM_LB, addr: 32'h0, wdata: 32'h0};
            wait_cnt    <= '0;
            dmem_req_o  <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= 32'h0;
            rsp_err_q   <= ERR_NONE;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        req_q <= '{op: op_in, addr: addr_i, wdata: wdata_i};
                        // Misalignment outranks the window check.
                        if (is_misaligned(op_in, addr_i[1:0])) begin
                            state       <= RESP;
                            rsp_valid_o <= 1'b1;
                            rsp_err_q   <= ERR_MISALIGN;
                        end else if (!in_ram(addr_i[31:2])) begin
                            state       <= RESP;
                            rsp_valid_o <= 1'b1;
                            rsp_err_q   <= ERR_ACCESS;
                        end else begin
                            state      <= REQ;
                            dmem_req_o <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (dmem_gnt_i) begin
                        dmem_req_o <= 1'b0;
                        if (is_store(req_q.op)) begin
                            state       <= RESP;
                            rsp_valid_o <= 1'b1;
                            rsp_err_q   <= ERR_NONE;
                        end else begin
                            state    <= WAIT;
                            wait_cnt <= '0;
                        end
                    end
                end
                WAIT: begin
                    // rvalid on the limit cycle still delivers data.
                    if (dmem_rvalid_i) begin
                        state       <= RESP;
                        rsp_valid_o <= 1'b1;
                        rsp_rdata_o <= load_data;
                        rsp_err_q   <= ERR_NONE;
                    end else if (wait_cnt == CNT_LIMIT) begin
                        state       <= RESP;
                        rsp_valid_o <= 1'b1;
                        rsp_err_q   <= ERR_TIMEOUT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RESP: begin
                    state       <= IDLE;
                    rsp_valid_o <= 1'b0;
                    rsp_rdata_o <= 32'h0;
                    rsp_err_q   <= ERR_NONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_unit.sv
module tb_lsu_unit;
    import lsu_unit_pkg::*;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  mem_op = 3'd0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        dmem_req, dmem_we;
    logic [29:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        gnt = 1'b0;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;

    int n_chk  = 0;
    int n_fail = 0;

    lsu_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .mem_op_i(mem_op), .addr_i(addr), .wdata_i(wdata),
        .dmem_req_o(dmem_req), .dmem_we_o(dmem_we), .dmem_addr_o(dmem_addr),
        .dmem_be_o(dmem_be), .dmem_wdata_o(dmem_wdata),
        .dmem_gnt_i(gnt), .dmem_rvalid_i(rvalid), .dmem_rdata_i(rdata),
        .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---- reference model: access size, window and lane arithmetic ----
    function automatic int op_size(input mem_op_t op);
        if (op == MEM_LW || op == MEM_SW) return 4;
        if (op == MEM_LH || op == MEM_LHU || op == MEM_SH) return 2;
        return 1;
    endfunction

    function automatic logic [1:0] m_err(input mem_op_t op, input logic [31:0] a);
        if ((a % op_size(op)) != 0) return 2'b01;
        if (a < 32'h8000_0000 || a > 32'h8000_FFFF) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [3:0] m_be(input mem_op_t op, input logic [31:0] a);
        int off = int'(a % 4);
        if (op == MEM_SB) return 4'(1 << off);
        if (op == MEM_SH) return 4'(3 << off);
        if (op == MEM_SW) return 4'hF;
        return 4'h0;
    endfunction

    function automatic logic [31:0] m_wd(input mem_op_t op, input logic [31:0] d);
        if (op == MEM_SB) return (d % 256) * 32'h0101_0101;
        if (op == MEM_SH) return (d % 65536) * 32'h0001_0001;
        if (op == MEM_SW) return d;
        return 32'h0;
    endfunction

    function automatic logic [31:0] m_ld(input mem_op_t op, input logic [31:0] a, input logic [31:0] w);
        int unsigned off = a % 4;
        logic [31:0] v;
        if (op == MEM_LW) return w;
        if (op == MEM_LB || op == MEM_LBU) begin
            v = (w >> (8 * off)) % 256;
            if (op == MEM_LB && v >= 128) v = v + 32'hFFFF_FF00;
            return v;
        end
        v = (w >> (8 * off)) % 65536;
        if (op == MEM_LH && v >= 32768) v = v + 32'hFFFF_0000;
        return v;
    endfunction

    // One complete operation. gnt_dly: REQ cycles before grant.
    // rv_dly: WAIT cycles before rvalid (>= TO means never).
    task automatic do_op(input mem_op_t op, input logic [31:0] a, input logic [31:0] wd,
                         input int gnt_dly, input int rv_dly, input logic [31:0] rd);
        logic [1:0] e;
        bit st, got;
        int k, exp_k;
        e  = m_err(op, a);
        st = (op == MEM_SB || op == MEM_SH || op == MEM_SW);
        chk("ready_before", req_ready, 1);
        req_valid = 1'b1; mem_op = op; addr = a; wdata = wd;
        step();
        req_valid = 1'b0; addr = $urandom; wdata = $urandom;
        if (e != 2'b00) begin
            chk("err_no_req", dmem_req, 0);
            chk("err_rsp_valid", rsp_valid, 1);
            chk("err_code", rsp_err, e);
            chk("err_rdata", rsp_rdata, 0);
        end else begin
            for (int g = 0; g <= gnt_dly; g++) begin
                chk("req_held", dmem_req, 1);
                chk("req_addr", dmem_addr, a / 4);
                chk("req_we", dmem_we, st);
                chk("req_be", dmem_be, m_be(op, a));
                chk("req_wdata", dmem_wdata, m_wd(op, wd));
                chk("req_no_rsp", rsp_valid, 0);
                // stray rvalid outside WAIT must be ignored
                rvalid = 1'($urandom_range(0, 1)); rdata = $urandom;
                gnt = (g == gnt_dly);
                step();
                gnt = 1'b0; rvalid = 1'b0;
            end
            chk("req_dropped", dmem_req, 0);
            if (st) begin
                chk("st_rsp_valid", rsp_valid, 1);
                chk("st_err", rsp_err, 0);
                chk("st_rdata", rsp_rdata, 0);
            end else begin
                chk("ld_no_early_rsp", rsp_valid, 0);
                got = 1'b0;
                for (k = 0; k < TO + 4 && !got; k++) begin
                    rvalid = (k == rv_dly);
                    rdata  = (k == rv_dly) ? rd : $urandom;
                    step();
                    rvalid = 1'b0;
                    got = rsp_valid;
                end
                exp_k = (rv_dly < TO) ? rv_dly : TO - 1;
                chk("ld_wait_len", k - 1, exp_k);
                chk("ld_rsp_valid", rsp_valid, 1);
                chk("ld_err", rsp_err, (rv_dly < TO) ? 2'b00 : 2'b11);
                chk("ld_rdata", rsp_rdata, (rv_dly < TO) ? m_ld(op, a, rd) : 32'h0);
            end
        end
        step();
        chk("rsp_one_pulse", rsp_valid, 0);
        chk("ready_after", req_ready, 1);
    endtask

    initial begin
        mem_op_t ro;
        logic [31:0] ra;
        bit seen;

        // Reset state
        step(); step();
        chk("rst_ready", req_ready, 1);
        chk("rst_req", dmem_req, 0);
        chk("rst_we", dmem_we, 0);
        chk("rst_addr", dmem_addr, 0);
        chk("rst_be", dmem_be, 0);
        chk("rst_wdata", dmem_wdata, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_err", rsp_err, 0);
        rst = 1'b0;
        step();

        // 1. LB sign-extension, rvalid in first WAIT cycle
        do_op(MEM_LB, 32'h8000_0003, 32'h0, 0, 0, 32'h80FF_1234);
        chk("t1_value", m_ld(MEM_LB, 32'h8000_0003, 32'h80FF_1234), 32'hFFFF_FF80);
        // 2. SH on upper half
        do_op(MEM_SH, 32'h8000_0102, 32'hABCD_5678, 0, 0, 32'h0);
        // 3. misalign and access errors, plus window edges
        do_op(MEM_LW, 32'h8000_0006, 32'h0, 0, 0, 32'h0);
        do_op(MEM_LHU, 32'h0000_0010, 32'h0, 0, 0, 32'h0);
        do_op(MEM_SW, 32'h7FFF_FFFC, 32'h1, 0, 0, 32'h0);
        do_op(MEM_LW, 32'h8000_FFFC, 32'h0, 0, 2, 32'hCAFE_F00D);
        do_op(MEM_SW, 32'h8001_0000, 32'h1, 0, 0, 32'h0);
        do_op(MEM_SH, 32'h9000_0001, 32'h1, 0, 0, 32'h0);
        // 4. grant withheld 5 cycles, then LW timeout
        do_op(MEM_LW, 32'h8000_0040, 32'h0, 5, 99, 32'h0);
        do_op(MEM_SB, 32'h8000_0041, 32'h0000_00A5, 5, 0, 32'h0);

        // 5. reset during WAIT, late rvalid must not produce a response
        req_valid = 1'b1; mem_op = MEM_LW; addr = 32'h8000_0100;
        step();
        req_valid = 1'b0;
        gnt = 1'b1;
        step();
        gnt = 1'b0;
        step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_ready", req_ready, 1);
        chk("rst_mid_req", dmem_req, 0);
        chk("rst_mid_rsp", rsp_valid, 0);
        seen = 1'b0;
        rvalid = 1'b1; rdata = 32'h1234_5678;
        step();
        rvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            seen |= rsp_valid;
            step();
        end
        chk("rst_mid_no_rsp", seen, 0);
        chk("rst_mid_idle", req_ready, 1);

        // 6. back-to-back loads with rvalid on the limit cycle
        do_op(MEM_LBU, 32'h8000_0202, 32'h0, 0, TO - 1, 32'h11F2_3344);
        do_op(MEM_LHU, 32'h8000_0206, 32'h0, 0, TO - 1, 32'hBEEF_0001);
        do_op(MEM_LW,  32'h8000_0208, 32'h0, 0, TO - 1, 32'hDEAD_BEEF);

        // Randomized operations
        for (int n = 0; n < 40; n++) begin
            ro = mem_op_t'($urandom_range(0, 7));
            case ($urandom_range(0, 9))
                0:       ra = $urandom;
                1:       ra = 32'h8001_0000 + $urandom_range(0, 15);
                2:       ra = 32'h7FFF_FFF0 + $urandom_range(0, 15);
                default: ra = 32'h8000_0000 + $urandom_range(0, 16'hFFFF);
            endcase
            do_op(ro, ra, $urandom, $urandom_range(0, 3), $urandom_range(0, TO + 1), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
